// File: rtl/synth_pkg.sv
// synth_pkg: shared widths for the synthesizer sample stream and I2S framing
package synth_pkg;
   localparam int SAMPLE_W       = 24;
   localparam int STREAM_W       = 32;
   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous DEPTH x SAMPLE_W FIFO with show-ahead head word
// ports: clk/n_rst, push+din in, pop in, dout (head), full, empty, level (occupancy)
module sample_fifo
   import synth_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  push,
   input  logic [SAMPLE_W-1:0]   din,
   input  logic                  pop,
   output logic [SAMPLE_W-1:0]   dout,
   output logic                  full,
   output logic                  empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   logic [SAMPLE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic push_ok, pop_ok;
   assign full  = cnt_q == CNT_FULL;
   assign empty = cnt_q == '0;
   assign dout  = mem_q[rd_q];
   assign level = cnt_q;
   always_comb begin
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop_ok);
      cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/synth_i2s_sink.sv
// synth_i2s_sink: Avalon-ST sample sink that plays a mono stream as an I2S stereo frame
// ports: clk/n_rst; asi_snk0_{data,valid,ready} stream in; o_bclk/o_lrck/o_sdata I2S out;
//        o_underrun pulse on an empty frame start (once primed); o_level FIFO occupancy
module synth_i2s_sink
   import synth_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [STREAM_W-1:0]    asi_snk0_data,
   input  logic                   asi_snk0_valid,
   output logic                   asi_snk0_ready,
   output logic                   o_bclk,
   output logic                   o_lrck,
   output logic                   o_sdata,
   output logic                   o_underrun,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
   localparam int BW = $clog2(I2S_FRAME_BITS);
   localparam int SW = $clog2(I2S_SLOT_BITS);
   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [SAMPLE_W-1:0] hold_q, hold_d, head;
   logic bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
   logic underrun_q, underrun_d, primed_q, primed_d;
   logic tc, fall, frame_start, push, pop, full, empty;
   logic [SW-1:0] s, idx;
   logic unused_hi;
   assign unused_hi      = |asi_snk0_data[STREAM_W-1:SAMPLE_W];
   assign asi_snk0_ready = ~full;
   assign push           = asi_snk0_valid & ~full;
   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .din   (asi_snk0_data[SAMPLE_W-1:0]),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (o_level)
   );
   always_comb begin
      tc          = div_q == DW'(BCLK_DIV - 1);
      fall        = tc & bclk_q;
      div_d       = tc ? '0 : div_q + DW'(1);
      bclk_d      = bclk_q ^ tc;
      bit_d       = bit_q + BW'(fall);
      s           = bit_d[SW-1:0];
      idx         = SW'(SAMPLE_W) - s;
      // slot bit 0 is the I2S one-bit delay; bits 1..24 carry the sample MSB first
      frame_start = fall & (bit_d == '0);
      pop         = frame_start & ~empty;
      lrck_d      = fall ? bit_d[BW-1] : lrck_q;
      sdata_d     = fall ? (s != '0 && s <= SW'(SAMPLE_W) ? hold_q[idx] : 1'b0) : sdata_q;
      hold_d      = frame_start ? (empty ? '0 : head) : hold_q;
      underrun_d  = frame_start & empty & primed_q;
      primed_d    = primed_q | push;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         div_q      <= '0;
         bit_q      <= '0;
         hold_q     <= '0;
         bclk_q     <= 1'b0;
         lrck_q     <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         primed_q   <= 1'b0;
      end else begin
         div_q      <= div_d;
         bit_q      <= bit_d;
         hold_q     <= hold_d;
         bclk_q     <= bclk_d;
         lrck_q     <= lrck_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         primed_q   <= primed_d;
      end
   end
   assign o_bclk     = bclk_q;
   assign o_lrck     = lrck_q;
   assign o_sdata    = sdata_q;
   assign o_underrun = underrun_q;
endmodule

// File: tb/tb_synth_i2s_sink.sv
// tb_synth_i2s_sink: directed self-checking bench for synth_i2s_sink (DEPTH=16, BCLK_DIV=2)
module tb_synth_i2s_sink;
   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] data = '0;
   logic        ready, bclk, lrck, sdata, underrun;
   logic [4:0]  level;
   int          n_chk = 0;
   int          n_pass = 0;
   int          uf_cnt = 0;
   logic [63:0] f;
   int          acc, u0;

   synth_i2s_sink #(.DEPTH(16), .BCLK_DIV(2)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .asi_snk0_data  (data),
      .asi_snk0_valid (valid),
      .asi_snk0_ready (ready),
      .o_bclk         (bclk),
      .o_lrck         (lrck),
      .o_sdata        (sdata),
      .o_underrun     (underrun),
      .o_level        (level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (underrun) uf_cnt <= uf_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [23:0] word(input logic [63:0] fr, input int base);
      logic [23:0] w;
      for (int i = 0; i < 24; i++) w[23-i] = fr[base+1+i];
      return w;
   endfunction

   function automatic logic [15:0] pad(input logic [63:0] fr);
      return {fr[0], fr[31:25], fr[32], fr[63:57]};
   endfunction

   task automatic push(input logic [31:0] w);
      logic r;
      int t;
      valid = 1'b1;
      data  = w;
      t = 0;
      do begin
         r = ready;
         @(negedge clk);
         t++;
      end while (!r && t < 600);
      valid = 1'b0;
      if (!r) check("push_timeout", 32'(r), 32'd1);
   endtask

   task automatic wait_fs();
      logic p, ok;
      p  = lrck;
      ok = 1'b0;
      for (int t = 0; t < 600 && !ok; t++) begin
         @(negedge clk);
         ok = p && !lrck;
         p  = lrck;
      end
      if (!ok) check("fs_timeout", 32'(ok), 32'd1);
   endtask

   task automatic grab(output logic [63:0] fr);
      fr[0] = sdata;
      for (int k = 1; k < 64; k++) begin
         repeat (4) @(negedge clk);
         fr[k] = sdata;
      end
   endtask

   task automatic capture(output logic [63:0] fr);
      wait_fs();
      grab(fr);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_bclk", 32'(bclk), 32'd0);
      check("rst_lrck", 32'(lrck), 32'd0);
      check("rst_sdata", 32'(sdata), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      n_rst = 1'b1;
      repeat (700) @(negedge clk);
      check("no_underrun_unprimed", 32'(uf_cnt), 32'd0);

      wait_fs();
      push(32'h00800001);
      push(32'hFF123456);
      push(32'h00000000);
      check("fmt_level3", 32'(level), 32'd3);
      capture(f);
      check("fmt1_left", 32'(word(f, 0)), 32'h800001);
      check("fmt1_right", 32'(word(f, 32)), 32'h800001);
      check("fmt1_pad", 32'(pad(f)), 32'd0);
      capture(f);
      check("fmt2_left", 32'(word(f, 0)), 32'h123456);
      check("fmt2_right", 32'(word(f, 32)), 32'h123456);
      check("fmt2_pad", 32'(pad(f)), 32'd0);
      check("fmt_level1", 32'(level), 32'd1);
      u0 = uf_cnt;
      capture(f);
      check("fmt3_zero_lo", f[31:0], 32'd0);
      check("fmt3_no_underrun", 32'(uf_cnt - u0), 32'd0);

      u0 = uf_cnt;
      wait_fs();
      check("unr_at_fs", 32'(underrun), 32'd1);
      grab(f);
      check("unr_once", 32'(uf_cnt - u0), 32'd1);
      check("unr_silent_lo", f[31:0], 32'd0);
      check("unr_silent_hi", f[63:32], 32'd0);

      wait_fs();
      valid = 1'b1;
      data  = 32'h100;
      acc   = 0;
      for (int t = 0; t < 40; t++) begin
         logic r;
         r = ready;
         @(negedge clk);
         if (!r) break;
         acc++;
         data = 32'h100 + 32'(acc);
      end
      check("bp_accepts", 32'(acc), 32'd16);
      check("bp_level_full", 32'(level), 32'd16);
      check("bp_ready_low", 32'(ready), 32'd0);
      wait_fs();
      check("bp_pop_level", 32'(level), 32'd15);
      check("bp_ready_back", 32'(ready), 32'd1);
      @(negedge clk);
      check("bp_17th_level", 32'(level), 32'd16);
      check("bp_17th_ready", 32'(ready), 32'd0);
      valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         capture(f);
         check($sformatf("bp_order%0d", i), 32'(word(f, 0)), 32'h100 + 32'(i));
      end
      check("bp_drained", 32'(level), 32'd0);

      wait_fs();
      valid = 1'b1;
      data  = 32'h000A0A0A;
      @(negedge clk);
      valid = 1'b0;
      check("sp_level1", 32'(level), 32'd1);
      repeat (254) @(negedge clk);
      valid = 1'b1;
      data  = 32'h000B0B0B;
      @(negedge clk);
      valid = 1'b0;
      check("sp_level_same", 32'(level), 32'd1);
      check("sp_frame_start", 32'(lrck), 32'd0);
      check("sp_no_underrun", 32'(underrun), 32'd0);
      grab(f);
      check("sp_first", 32'(word(f, 0)), 32'h0A0A0A);
      capture(f);
      check("sp_second", 32'(word(f, 0)), 32'h0B0B0B);
      check("sp_level0", 32'(level), 32'd0);

      wait_fs();
      repeat (255) @(negedge clk);
      valid = 1'b1;
      data  = 32'h000C0C0C;
      @(negedge clk);
      valid = 1'b0;
      check("ep_underrun", 32'(underrun), 32'd1);
      check("ep_level1", 32'(level), 32'd1);
      capture(f);
      check("ep_sample", 32'(word(f, 0)), 32'h0C0C0C);
      check("ep_level0", 32'(level), 32'd0);

      push(32'hFFFFFFFF);
      push(32'hFFFFFFFF);
      push(32'hFFFFFFFF);
      wait_fs();
      repeat (138) @(negedge clk);
      check("mid_pre_bclk", 32'(bclk), 32'd1);
      check("mid_pre_lrck", 32'(lrck), 32'd1);
      check("mid_pre_sdata", 32'(sdata), 32'd1);
      check("mid_pre_level", 32'(level), 32'd2);
      u0 = uf_cnt;
      n_rst = 1'b0;
      #1;
      check("mid_rst_bclk", 32'(bclk), 32'd0);
      check("mid_rst_lrck", 32'(lrck), 32'd0);
      check("mid_rst_sdata", 32'(sdata), 32'd0);
      check("mid_rst_underrun", 32'(underrun), 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_ready", 32'(ready), 32'd1);
      repeat (20) @(negedge clk);
      check("mid_rst_no_pulse", 32'(uf_cnt - u0), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
